// File: rtl/fft_frame_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_frame_buffer_pkg
// Description : Shared definitions for the FFT frame buffer and FFT core:
//               read-FSM state encoding and the index bit-reverse helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_frame_buffer_pkg;

    // Read-side FSM encoding
    typedef logic [0:0] state_t;
    localparam state_t c_ST_IDLE = 1'b0;
    localparam state_t c_ST_READ = 1'b1;

    // Largest supported log2 frame length
    localparam int c_MAX_LOG2 = 10;

    // Reverse the low 'width' bits of val. The whole vector is mirrored and
    // then shifted down so the mirrored field lands at bit 0. Callers pass a
    // constant width, so this reduces to pure wiring.
    function automatic logic [c_MAX_LOG2-1:0] bit_reverse(
        input logic [c_MAX_LOG2-1:0] val,
        input int                    width
    );
        logic [c_MAX_LOG2-1:0] rev;
        for (int i = 0; i < c_MAX_LOG2; i++) begin
            rev[i] = val[c_MAX_LOG2-1-i];
        end
        return rev >> (c_MAX_LOG2 - width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_pp_bank.sv
`default_nettype none
// ============================================================================
// Module      : fft_pp_bank
// Description : One N x DATA_W storage bank of the ping-pong frame buffer.
//               Synchronous write port, asynchronous read port.
// Ports       : clk     - clock
//               i_we    - write enable
//               i_waddr - write address
//               i_wdata - write data
//               i_raddr - read address
//               o_rdata - read data (combinational from i_raddr)
// Revision    : 1.0 - initial release
// ============================================================================
module fft_pp_bank
    import fft_frame_buffer_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int N_LOG2 = 3
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [N_LOG2-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [N_LOG2-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [1 << N_LOG2];

    // Memory is deliberately not reset; the full flags qualify its content.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/fft_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fft_frame_buffer
// Description : Ping-pong frame buffer feeding an FFT core. Collects frames
//               of N = 2**N_LOG2 samples into alternating banks and reads
//               each full frame out in bit-reversed (BITREV=1) or natural
//               (BITREV=0) index order with a valid/ready handshake.
// Ports       : clk        - clock
//               rst        - synchronous active-high reset
//               en / inp   - input sample strobe and sample
//               outp_ready - downstream ready
//               outp       - registered output sample
//               outp_valid - outp holds a valid sample
//               outp_idx   - write-order index of the sample on outp
//               outp_last  - final sample of the frame
//               overflow   - one-cycle pulse per dropped input sample
// Revision    : 1.0 - initial release
// ============================================================================
module fft_frame_buffer
    import fft_frame_buffer_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int N_LOG2 = 3,
    parameter int BITREV = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] inp,
    input  logic              outp_ready,
    output logic [DATA_W-1:0] outp,
    output logic              outp_valid,
    output logic [N_LOG2-1:0] outp_idx,
    output logic              outp_last,
    output logic              overflow
);

    // ---------------- state ----------------
    logic [N_LOG2-1:0] r_wr_cnt;
    logic              r_wr_bank;
    logic [1:0]        r_full;
    logic              r_rd_bank;
    logic [N_LOG2-1:0] r_rd_cnt;
    state_t            r_state;
    logic [DATA_W-1:0] r_outp;
    logic              r_outp_valid;
    logic [N_LOG2-1:0] r_outp_idx;
    logic              r_outp_last;
    logic              r_overflow;

    // ---------------- combinational ----------------
    logic              w_load;
    logic              w_rd_last;
    logic              w_free;
    logic              w_writable;
    logic              w_wr_acc;
    logic              w_wr_wrap;
    logic [1:0]        w_full_nxt;
    state_t            w_state_nxt;
    logic [N_LOG2-1:0] w_rd_addr;
    logic [DATA_W-1:0] w_bank_rdata [2];
    logic [DATA_W-1:0] w_rdata;

    assign w_load    = (r_state == c_ST_READ) && (!r_outp_valid || outp_ready);
    assign w_rd_last = (r_rd_cnt == '1);
    // The bank under readout is released on the load of its last sample.
    assign w_free    = w_load && w_rd_last;

    // A full bank still accepts a write in the very cycle it is released,
    // which is what keeps continuous streaming free of drops.
    assign w_writable = !r_full[r_wr_bank] || (w_free && (r_rd_bank == r_wr_bank));
    assign w_wr_acc   = en && w_writable;
    assign w_wr_wrap  = w_wr_acc && (r_wr_cnt == '1);

    always_comb begin
        w_full_nxt = r_full;
        for (int b = 0; b < 2; b++) begin
            if (w_free && (r_rd_bank == 1'(b))) begin
                w_full_nxt[b] = 1'b0;
            end
            if (w_wr_wrap && (r_wr_bank == 1'(b))) begin
                w_full_nxt[b] = 1'b1;
            end
        end
    end

    // Next-state logic. Looking at the next-cycle full flag of the other
    // bank lets a frame completing this very cycle be chained without a gap.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (r_full[r_rd_bank]) begin
                    w_state_nxt = c_ST_READ;
                end
            end
            c_ST_READ: begin
                if (w_free) begin
                    w_state_nxt = w_full_nxt[~r_rd_bank] ? c_ST_READ : c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Read address ordering
    generate
        if (BITREV != 0) begin : g_bitrev
            assign w_rd_addr = N_LOG2'(bit_reverse(c_MAX_LOG2'(r_rd_cnt), N_LOG2));
        end else begin : g_natural
            assign w_rd_addr = r_rd_cnt;
        end
    endgenerate

    // Storage banks
    generate
        for (genvar b = 0; b < 2; b++) begin : g_bank
            fft_pp_bank #(
                .DATA_W (DATA_W),
                .N_LOG2 (N_LOG2)
            ) u_bank (
                .clk     (clk),
                .i_we    (w_wr_acc && (r_wr_bank == 1'(b))),
                .i_waddr (r_wr_cnt),
                .i_wdata (inp),
                .i_raddr (w_rd_addr),
                .o_rdata (w_bank_rdata[b])
            );
        end
    endgenerate

    assign w_rdata = w_bank_rdata[r_rd_bank];

    // ---------------- sequential ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_cnt     <= '0;
            r_wr_bank    <= 1'b0;
            r_full       <= 2'b00;
            r_rd_bank    <= 1'b0;
            r_rd_cnt     <= '0;
            r_state      <= c_ST_IDLE;
            r_outp       <= '0;
            r_outp_valid <= 1'b0;
            r_outp_idx   <= '0;
            r_outp_last  <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_full     <= w_full_nxt;
            r_overflow <= en && !w_writable;

            if (w_wr_acc) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
                if (w_wr_wrap) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end

            if (r_state == c_ST_IDLE) begin
                r_rd_cnt <= '0;
            end

            if (w_load) begin
                r_outp       <= w_rdata;
                r_outp_idx   <= w_rd_addr;
                r_outp_last  <= w_rd_last;
                r_outp_valid <= 1'b1;
                r_rd_cnt     <= r_rd_cnt + 1'b1;
                if (w_rd_last) begin
                    r_rd_bank <= ~r_rd_bank;
                end
            end else if (outp_ready) begin
                r_outp_valid <= 1'b0;
            end
        end
    end

    assign outp       = r_outp;
    assign outp_valid = r_outp_valid;
    assign outp_idx   = r_outp_idx;
    assign outp_last  = r_outp_last;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_frame_buffer
// Description : Self-checking bench for fft_frame_buffer. Three instances:
//               default (bit-reversed, N=8), natural order (BITREV=0) and
//               wide (DATA_W=24, N_LOG2=4). Expected samples are queued
//               when stimulus is driven and compared as outputs are accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_frame_buffer;

    typedef struct packed {
        logic [23:0] d;
        logic [3:0]  idx;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // instance A: defaults
    logic        a_en = 0, a_ready = 1;
    logic [15:0] a_inp = '0, a_outp;
    logic        a_valid, a_last, a_ovf;
    logic [2:0]  a_idx;
    // instance B: natural order
    logic        b_en = 0, b_ready = 1;
    logic [15:0] b_inp = '0, b_outp;
    logic        b_valid, b_last, b_ovf;
    logic [2:0]  b_idx;
    // instance C: wide, N=16
    logic        c_en = 0, c_ready = 1;
    logic [23:0] c_inp = '0, c_outp;
    logic        c_valid, c_last, c_ovf;
    logic [3:0]  c_idx;

    fft_frame_buffer u_dut_a (
        .clk(clk), .rst(rst), .en(a_en), .inp(a_inp), .outp_ready(a_ready),
        .outp(a_outp), .outp_valid(a_valid), .outp_idx(a_idx),
        .outp_last(a_last), .overflow(a_ovf));

    fft_frame_buffer #(.BITREV(0)) u_dut_b (
        .clk(clk), .rst(rst), .en(b_en), .inp(b_inp), .outp_ready(b_ready),
        .outp(b_outp), .outp_valid(b_valid), .outp_idx(b_idx),
        .outp_last(b_last), .overflow(b_ovf));

    fft_frame_buffer #(.DATA_W(24), .N_LOG2(4)) u_dut_c (
        .clk(clk), .rst(rst), .en(c_en), .inp(c_inp), .outp_ready(c_ready),
        .outp(c_outp), .outp_valid(c_valid), .outp_idx(c_idx),
        .outp_last(c_last), .overflow(c_ovf));

    int   errors = 0;
    int   checks = 0;
    exp_t q_a[$], q_b[$], q_c[$];
    int   a_out_cnt = 0, b_out_cnt = 0, c_out_cnt = 0;
    int   a_ovf_cnt = 0, b_ovf_cnt = 0, c_ovf_cnt = 0;

    function automatic int rev(input int v, input int w);
        int r = 0;
        for (int i = 0; i < w; i++) r |= ((v >> i) & 1) << (w - 1 - i);
        return r;
    endfunction

    function automatic exp_t mk(input int d, input int idx, input bit last);
        exp_t e;
        e.d = 24'(d); e.idx = 4'(idx); e.last = last;
        return e;
    endfunction

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (a_ovf) a_ovf_cnt++;
            if (a_valid && a_ready) begin
                a_out_cnt++; checks++;
                if (q_a.size() == 0) begin
                    errors++;
                    $display("FAIL a_extra: got outp=%0d idx=%0d, expected no output", a_outp, a_idx);
                end else begin
                    e = q_a.pop_front();
                    if (a_outp !== e.d[15:0] || a_idx !== e.idx[2:0] || a_last !== e.last) begin
                        errors++;
                        $display("FAIL a_sample: got outp=%0d idx=%0d last=%0b, expected %0d/%0d/%0b",
                                 a_outp, a_idx, a_last, e.d[15:0], e.idx[2:0], e.last);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (b_ovf) b_ovf_cnt++;
            if (b_valid && b_ready) begin
                b_out_cnt++; checks++;
                if (q_b.size() == 0) begin
                    errors++;
                    $display("FAIL b_extra: got outp=%0d idx=%0d, expected no output", b_outp, b_idx);
                end else begin
                    e = q_b.pop_front();
                    if (b_outp !== e.d[15:0] || b_idx !== e.idx[2:0] || b_last !== e.last) begin
                        errors++;
                        $display("FAIL b_sample: got outp=%0d idx=%0d last=%0b, expected %0d/%0d/%0b",
                                 b_outp, b_idx, b_last, e.d[15:0], e.idx[2:0], e.last);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (c_ovf) c_ovf_cnt++;
            if (c_valid && c_ready) begin
                c_out_cnt++; checks++;
                if (q_c.size() == 0) begin
                    errors++;
                    $display("FAIL c_extra: got outp=%h idx=%0d, expected no output", c_outp, c_idx);
                end else begin
                    e = q_c.pop_front();
                    if (c_outp !== e.d || c_idx !== e.idx || c_last !== e.last) begin
                        errors++;
                        $display("FAIL c_sample: got outp=%h idx=%0d last=%0b, expected %h/%0d/%0b",
                                 c_outp, c_idx, c_last, e.d, e.idx, e.last);
                    end
                end
            end
        end
    end

    // ---------------- helpers (stimulus / waiting only) ----------------
    task automatic drain(input int which);
        for (int n = 0; n < 200; n++) begin
            if ((which == 0 && q_a.size() == 0) || (which == 1 && q_b.size() == 0) ||
                (which == 2 && q_c.size() == 0)) break;
            @(posedge clk);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input int first, input int count);
        for (int i = 0; i < count; i++) begin
            a_en = 1'b1; a_inp = 16'(first + i);
            @(posedge clk); #1;
        end
        a_en = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, expected 0", a_valid); end
        checks++; if (a_outp !== 16'd0) begin errors++; $display("FAIL rst_outp: got %0d, expected 0", a_outp); end
        checks++; if (a_idx !== 3'd0) begin errors++; $display("FAIL rst_idx: got %0d, expected 0", a_idx); end
        checks++; if (a_last !== 1'b0) begin errors++; $display("FAIL rst_last: got %b, expected 0", a_last); end
        checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b, expected 0", a_ovf); end
        checks++; if (b_valid !== 1'b0) begin errors++; $display("FAIL rst_b_valid: got %b, expected 0", b_valid); end
        checks++; if (c_outp !== 24'd0 || c_valid !== 1'b0) begin errors++; $display("FAIL rst_c: got outp=%h valid=%b, expected 0/0", c_outp, c_valid); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_bitrev_frame;
        a_out_cnt = 0;
        for (int i = 0; i < 8; i++) q_a.push_back(mk(100 + rev(i, 3), rev(i, 3), i == 7));
        drive_a(100, 8);
        // now just after the edge that sampled 107
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL lat_early0: got valid=%b, expected 0", a_valid); end
        @(posedge clk); #1;
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL lat_early1: got valid=%b, expected 0", a_valid); end
        @(posedge clk); #1;
        checks++; if (a_valid !== 1'b1 || a_outp !== 16'd100) begin errors++; $display("FAIL lat_first: got valid=%b outp=%0d, expected 1/100", a_valid, a_outp); end
        drain(0);
        checks++; if (q_a.size() != 0 || a_out_cnt != 8) begin errors++; $display("FAIL bitrev_count: got %0d outputs (%0d pending), expected 8 (0)", a_out_cnt, q_a.size()); end
    endtask

    task automatic test_back_to_back;
        int gaps = 0;
        a_out_cnt = 0; a_ovf_cnt = 0;
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < 8; i++) q_a.push_back(mk(100 + 8 * f + rev(i, 3), rev(i, 3), i == 7));
        fork
            drive_a(100, 24);
            repeat (80) begin
                @(negedge clk);
                if (!a_valid && a_out_cnt > 0 && a_out_cnt < 24) gaps++;
            end
        join
        drain(0);
        checks++; if (gaps != 0) begin errors++; $display("FAIL b2b_gaps: got %0d valid gaps, expected 0", gaps); end
        checks++; if (a_ovf_cnt != 0) begin errors++; $display("FAIL b2b_ovf: got %0d overflow pulses, expected 0", a_ovf_cnt); end
        checks++; if (a_out_cnt != 24 || q_a.size() != 0) begin errors++; $display("FAIL b2b_count: got %0d outputs, expected 24", a_out_cnt); end
    endtask

    task automatic test_overflow;
        a_out_cnt = 0; a_ovf_cnt = 0;
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 8; i++) q_a.push_back(mk(100 + 8 * f + rev(i, 3), rev(i, 3), i == 7));
        fork
            drive_a(100, 24);
            begin
                a_ready = 1'b0;
                repeat (20) @(posedge clk);
                #1 a_ready = 1'b1;
            end
        join
        drain(0);
        repeat (10) @(posedge clk);
        #1;
        checks++; if (a_ovf_cnt != 8) begin errors++; $display("FAIL ovf_pulses: got %0d, expected 8", a_ovf_cnt); end
        checks++; if (a_out_cnt != 16 || q_a.size() != 0) begin errors++; $display("FAIL ovf_outputs: got %0d outputs, expected 16", a_out_cnt); end
    endtask

    task automatic test_reset_mid_frame;
        a_out_cnt = 0;
        drive_a(200, 5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) q_a.push_back(mk(100 + rev(i, 3), rev(i, 3), i == 7));
        drive_a(100, 8);
        drain(0);
        repeat (10) @(posedge clk);
        #1;
        checks++; if (a_out_cnt != 8 || q_a.size() != 0) begin errors++; $display("FAIL rstmid_count: got %0d outputs, expected 8", a_out_cnt); end
    endtask

    task automatic test_natural_gap;
        b_out_cnt = 0; b_ovf_cnt = 0;
        for (int i = 0; i < 8; i++) q_b.push_back(mk(100 + i, i, i == 7));
        for (int i = 0; i < 12; i++) begin
            b_en  = (i < 4 || i >= 8);
            b_inp = 16'((i < 4) ? 100 + i : 100 + i - 4);
            @(posedge clk); #1;
        end
        b_en = 1'b0;
        drain(1);
        checks++; if (b_out_cnt != 8 || q_b.size() != 0) begin errors++; $display("FAIL nat_count: got %0d outputs, expected 8", b_out_cnt); end
        checks++; if (b_ovf_cnt != 0) begin errors++; $display("FAIL nat_ovf: got %0d overflow pulses, expected 0", b_ovf_cnt); end
    endtask

    task automatic test_wide;
        c_out_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            int a = rev(i, 4);
            q_c.push_back(mk((a % 2 == 0) ? 24'h7FFFFF : 24'h800000, a, i == 15));
        end
        for (int i = 0; i < 16; i++) begin
            c_en = 1'b1; c_inp = (i % 2 == 0) ? 24'h7FFFFF : 24'h800000;
            @(posedge clk); #1;
        end
        c_en = 1'b0;
        drain(2);
        checks++; if (c_out_cnt != 16 || q_c.size() != 0) begin errors++; $display("FAIL wide_count: got %0d outputs, expected 16", c_out_cnt); end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset;
        test_bitrev_frame;
        test_back_to_back;
        test_overflow;
        test_reset_mid_frame;
        test_natural_gap;
        test_wide;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
